// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_ctrl.
interface sync_fifo_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned PTR_SIZE  = 8
);
  logic                 w_en;
  logic [DATA_SIZE-1:0] data_in;
  logic                 r_en;
  logic                 flush;
  logic [DATA_SIZE-1:0] data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [PTR_SIZE:0]    count;
  logic                 write_error;
  logic                 read_error;

  // Side that drives requests and observes status.
  modport master (
    output w_en, data_in, r_en, flush,
    input  data_out, full, empty, almost_full, almost_empty, count,
           write_error, read_error
  );

  // The FIFO itself.
  modport slave (
    input  w_en, data_in, r_en, flush,
    output data_out, full, empty, almost_full, almost_empty, count,
           write_error, read_error
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and a build-time registered / first-word-fall-through read.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned PTR_SIZE  = 8,
  parameter int unsigned AF_LEVEL  = 252,
  parameter int unsigned AE_LEVEL  = 4,
  parameter int unsigned FWFT      = 0
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave bus
);

  localparam int unsigned CNT_W = PTR_SIZE + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [CNT_W-1:0] wptr_q, wptr_nxt;
  logic [CNT_W-1:0] rptr_q, rptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             full_q, full_nxt;
  logic             empty_q, empty_nxt;
  logic             afull_q, afull_nxt;
  logic             aempty_q, aempty_nxt;
  logic             werr_q, werr_nxt;
  logic             rerr_q, rerr_nxt;
  logic             wr_acc;
  logic             rd_acc;
  logic             mem_we;

  // Accept/reject decisions, pointer/count update and flag decode from the next count.
  always_comb begin
    wr_acc     = bus.w_en && !full_q;
    rd_acc     = bus.r_en && !empty_q;
    mem_we     = 1'b0;
    wptr_nxt   = wptr_q;
    rptr_nxt   = rptr_q;
    count_nxt  = count_q;
    werr_nxt   = 1'b0;
    rerr_nxt   = 1'b0;

    if (bus.flush) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      count_nxt = '0;
    end else begin
      mem_we   = wr_acc;
      werr_nxt = bus.w_en && full_q;
      rerr_nxt = bus.r_en && empty_q;
      if (wr_acc) wptr_nxt = wptr_q + CNT_W'(1);
      if (rd_acc) rptr_nxt = rptr_q + CNT_W'(1);
      if (wr_acc && !rd_acc) begin
        count_nxt = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_nxt = count_q - CNT_W'(1);
      end
    end

    full_nxt   = (count_nxt == CNT_W'(DEPTH));
    empty_nxt  = (count_nxt == '0);
    afull_nxt  = (count_nxt >= CNT_W'(AF_LEVEL));
    aempty_nxt = (count_nxt <= CNT_W'(AE_LEVEL));
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AF_LEVEL == 0);
      aempty_q <= 1'b1;
      werr_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_nxt;
      rptr_q   <= rptr_nxt;
      count_q  <= count_nxt;
      full_q   <= full_nxt;
      empty_q  <= empty_nxt;
      afull_q  <= afull_nxt;
      aempty_q <= aempty_nxt;
      werr_q   <= werr_nxt;
      rerr_q   <= rerr_nxt;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wptr_q[PTR_SIZE-1:0]] <= bus.data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; only meaningful while not empty.
      assign bus.data_out = mem[rptr_q[PTR_SIZE-1:0]];
    end else begin : g_reg
      logic [DATA_SIZE-1:0] dout_q;

      // Registered read port: loads the head word on an accepted pop, holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
        end else if (!bus.flush && rd_acc) begin
          dout_q <= mem[rptr_q[PTR_SIZE-1:0]];
        end
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.write_error  = werr_q;
  assign bus.read_error   = rerr_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a registered-output and an FWFT instance share one
// stimulus stream and are both compared against a queue-based reference.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned PW  = 4;
  localparam int unsigned AF  = 14;
  localparam int unsigned AE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_SIZE(DW), .PTR_SIZE(PW)) bus0 ();
  sync_fifo_if #(.DATA_SIZE(DW), .PTR_SIZE(PW)) bus1 ();

  sync_fifo_ctrl #(
    .DATA_SIZE(DW), .DEPTH(DEP), .PTR_SIZE(PW),
    .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  sync_fifo_ctrl #(
    .DATA_SIZE(DW), .DEPTH(DEP), .PTR_SIZE(PW),
    .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) dut_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Reference model: contents as a queue, plus the registered read word and error pulses.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_werr;
  logic          m_rerr;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("reg.count",        32'(bus0.count),        32'(n));
    chk("reg.full",         32'(bus0.full),         32'(n == DEP));
    chk("reg.empty",        32'(bus0.empty),        32'(n == 0));
    chk("reg.almost_full",  32'(bus0.almost_full),  32'(n >= AF));
    chk("reg.almost_empty", 32'(bus0.almost_empty), 32'(n <= AE));
    chk("reg.write_error",  32'(bus0.write_error),  32'(m_werr));
    chk("reg.read_error",   32'(bus0.read_error),   32'(m_rerr));
    chk("reg.data_out",     32'(bus0.data_out),     32'(m_dout));
    chk("fwft.count",       32'(bus1.count),        32'(n));
    chk("fwft.full",        32'(bus1.full),         32'(n == DEP));
    chk("fwft.empty",       32'(bus1.empty),        32'(n == 0));
    chk("fwft.write_error", 32'(bus1.write_error),  32'(m_werr));
    chk("fwft.read_error",  32'(bus1.read_error),   32'(m_rerr));
    if (n > 0) chk("fwft.data_out", 32'(bus1.data_out), 32'(q[0]));
  endtask

  // Apply one cycle of inputs to both instances, advance the model, then check.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic f);
    bit was_full, was_empty;
    rst          = r;
    bus0.w_en    = w;  bus1.w_en    = w;
    bus0.data_in = d;  bus1.data_in = d;
    bus0.r_en    = rd; bus1.r_en    = rd;
    bus0.flush   = f;  bus1.flush   = f;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else if (f) begin
      q.delete();
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      was_full  = (q.size() == DEP);
      was_empty = (q.size() == 0);
      m_werr = w && was_full;
      m_rerr = rd && was_empty;
      if (rd && !was_empty) m_dout = q.pop_front();
      if (w && !was_full)   q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] rnd;
    bus0.w_en = 1'b0; bus0.data_in = '0; bus0.r_en = 1'b0; bus0.flush = 1'b0;
    bus1.w_en = 1'b0; bus1.data_in = '0; bus1.r_en = 1'b0; bus1.flush = 1'b0;
    q.delete();
    m_dout = '0; m_werr = 1'b0; m_rerr = 1'b0;

    // Reset state.
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // Fill with 0x01..0x10, then overflow twice with 0xAA.
    for (int i = 1; i <= 16; i++) step(0, 1, DW'(i), 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    step(0, 1, 8'hAA, 0, 0);

    // Full with simultaneous write and read: read wins, write rejected.
    step(0, 1, 8'hAA, 1, 0);

    // Drain the remaining 15, then underflow twice.
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Empty with simultaneous write and read: write wins, read rejected.
    step(0, 1, 8'h3C, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Hold at occupancy 8 with concurrent traffic across pointer wrap.
    for (int i = 0; i < 8; i++) step(0, 1, DW'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, DW'($urandom), 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0);

    // Single word into empty: visible on the FWFT port without popping.
    step(0, 1, 8'h5C, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Flush at occupancy 9 with a concurrent write.
    for (int i = 0; i < 9; i++) step(0, 1, DW'($urandom), 0, 0);
    step(0, 1, 8'h77, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    step(0, 1, 8'h12, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Random traffic: write-biased, then read-biased, with sporadic flushes.
    for (int i = 0; i < 300; i++) begin
      rnd = DW'($urandom);
      step(0, ($urandom_range(0, 9) < 7), rnd, ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 300; i++) begin
      rnd = DW'($urandom);
      step(0, ($urandom_range(0, 9) < 4), rnd, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 63) == 0));
    end

    // Reset mid-stream with a write pending.
    for (int i = 0; i < 6; i++) step(0, 1, DW'($urandom), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(1, 1, 8'hEE, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
